// File: rtl/nav_input_sequencer.sv
// Button synchroniser/debouncer and one-command-per-press sequencer with a held-chord game reset.
// Optional auto-repeat while a single button stays held is enabled by defining NAV_AUTOREPEAT_EN.
module nav_input_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttons,
    input  logic       busy,
    output logic [2:0] direction,
    output logic       move,
    output logic       game_reset,
    output logic       pending
);

    localparam int unsigned DbWidth   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HoldWidth = $clog2(HOLD_CYCLES) + 1;
    localparam logic [DbWidth-1:0]   DbLast   = DbWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldWidth-1:0] HoldLast = HoldWidth'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StChord, StWaitRel} state_e;

    logic [3:0]           sync1_q, sync2_q, samp_q, stable_q;
    logic [DbWidth-1:0]   db_cnt_q;
    state_e               state_q, state_d;
    logic [2:0]           cmd_q, cmd_d;
    logic [HoldWidth-1:0] hold_q, hold_d;
    logic [2:0]           direction_q, direction_d;
    logic                 move_q, move_d;
    logic                 game_reset_q, game_reset_d;
    logic                 pending_q, pending_d;
    logic [2:0]           press_code;

`ifdef NAV_AUTOREPEAT_EN
    localparam int unsigned RepWidth = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RepWidth-1:0] RepLast = RepWidth'(REPEAT_CYCLES - 1);
    logic [RepWidth-1:0] rep_q, rep_d;
`endif

    // Debounce counter saturates at DbLast; stable keeps refreshing while the input stays put.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            samp_q   <= 4'b0000;
            stable_q <= 4'b0000;
            db_cnt_q <= '0;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;
            if (sync2_q != samp_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DbLast) begin
                stable_q <= samp_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        case (stable_q)
            4'b0001: press_code = 3'd1;
            4'b0010: press_code = 3'd2;
            4'b0100: press_code = 3'd0;
            4'b1000: press_code = 3'd3;
            default: press_code = 3'd7;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        hold_d       = '0;
        direction_d  = 3'd7;
        move_d       = 1'b0;
        game_reset_d = 1'b0;
        pending_d    = 1'b0;
`ifdef NAV_AUTOREPEAT_EN
        rep_d        = '0;
`endif
        case (state_q)
            StIdle: begin
                if (press_code != 3'd7) begin
                    cmd_d       = press_code;
                    direction_d = press_code;
                    state_d     = StIssue;
                end else if (stable_q == 4'b1111) begin
                    state_d = StChord;
                end
            end
            StIssue: begin
                direction_d = cmd_q;
                if (busy) begin
                    pending_d = 1'b1;
                end else begin
                    move_d  = 1'b1;
                    state_d = StWaitRel;
                end
            end
            StChord: begin
                if (stable_q != 4'b1111) begin
                    state_d = StWaitRel;
                end else if (hold_q == HoldLast) begin
                    game_reset_d = 1'b1;
                    state_d      = StWaitRel;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StWaitRel: begin
                if (stable_q == 4'b0000) begin
                    state_d = StIdle;
                end
`ifdef NAV_AUTOREPEAT_EN
                // Same single button still held: count towards the next repeat.
                else if (press_code == cmd_q) begin
                    if (rep_q == RepLast) begin
                        direction_d = cmd_q;
                        state_d     = StIssue;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            cmd_q        <= 3'd7;
            hold_q       <= '0;
            direction_q  <= 3'd7;
            move_q       <= 1'b0;
            game_reset_q <= 1'b0;
            pending_q    <= 1'b0;
`ifdef NAV_AUTOREPEAT_EN
            rep_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            hold_q       <= hold_d;
            direction_q  <= direction_d;
            move_q       <= move_d;
            game_reset_q <= game_reset_d;
            pending_q    <= pending_d;
`ifdef NAV_AUTOREPEAT_EN
            rep_q        <= rep_d;
`endif
        end
    end

    assign direction  = direction_q;
    assign move       = move_q;
    assign game_reset = game_reset_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_nav_input_sequencer.sv
// Scoreboard bench for nav_input_sequencer: a windowed reference model predicts pulses and status,
// a monitor compares them against the DUT; directed scenarios plus randomized button/busy traffic.
module tb_nav_input_sequencer;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 10;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_CHORD = 2;
    localparam int P_WAIT  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] buttons = 4'b0000;
    logic       busy = 1'b0;
    logic [2:0] direction;
    logic       move;
    logic       game_reset;
    logic       pending;

    always #5 clock = ~clock;

    nav_input_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .buttons   (buttons),
        .busy      (busy),
        .direction (direction),
        .move      (move),
        .game_reset(game_reset),
        .pending   (pending)
    );

    typedef struct {int kind; int dir; int cyc;} evt_t;   // kind 0 = move, 1 = game_reset
    typedef struct {int dir; int pend;} st_t;

    evt_t evq[$];
    st_t  stq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int   move_cycs[$];
    int   last_move_dir = -1;
    int   gr_count = 0;
    int   last_gr_cyc = -1;

    function automatic int code_of(input int v);
        case (v)
            1:       return 1;
            2:       return 2;
            4:       return 0;
            8:       return 3;
            default: return 7;
        endcase
    endfunction

    // Reference model: stable follows a vector once DB+1 consecutive synchronised samples agree.
    initial begin : ref_model
        int hist[$];
        int m_stable, m_phase, m_cmd, m_dir, m_pend, m_hold, m_rep;
        int mv, gr, n, ok;
        hist = '{0, 0, 0};
        m_stable = 0; m_phase = P_IDLE; m_cmd = 7; m_dir = 7; m_pend = 0; m_hold = 0; m_rep = 0;
        forever begin
            @(posedge clock);
            cyc++;
            mv = 0;
            gr = 0;
            if (!reset) begin
                hist = '{0, 0, 0};
                m_stable = 0; m_phase = P_IDLE; m_cmd = 7; m_dir = 7; m_pend = 0;
                m_hold = 0; m_rep = 0;
            end else begin
                hist.push_back(int'(buttons));
                m_dir = 7;
                m_pend = 0;
                if (m_phase != P_WAIT) m_rep = 0;
                if (m_phase == P_IDLE) begin
                    if (code_of(m_stable) != 7) begin
                        m_cmd = code_of(m_stable);
                        m_dir = m_cmd;
                        m_phase = P_ISSUE;
                    end else if (m_stable == 15) begin
                        m_phase = P_CHORD;
                        m_hold = 0;
                    end
                end else if (m_phase == P_ISSUE) begin
                    m_dir = m_cmd;
                    if (busy) m_pend = 1;
                    else begin
                        mv = 1;
                        m_phase = P_WAIT;
                    end
                end else if (m_phase == P_CHORD) begin
                    if (m_stable != 15) m_phase = P_WAIT;
                    else if (m_hold == HOLD - 1) begin
                        gr = 1;
                        m_phase = P_WAIT;
                    end else m_hold++;
                end else begin
                    if (m_stable == 0) m_phase = P_IDLE;
`ifdef NAV_AUTOREPEAT_EN
                    else if (code_of(m_stable) == m_cmd) begin
                        if (m_rep == REP - 1) begin
                            m_rep = 0;
                            m_dir = m_cmd;
                            m_phase = P_ISSUE;
                        end else m_rep++;
                    end else m_rep = 0;
`endif
                end
                n = hist.size();
                if (n >= DB + 3) begin
                    ok = 1;
                    for (int i = n - 3 - DB; i <= n - 3; i++)
                        if (hist[i] != hist[n-3]) ok = 0;
                    if (ok == 1) m_stable = hist[n-3];
                end
                while (hist.size() > DB + 8) void'(hist.pop_front());
            end
            stq.push_back('{m_dir, m_pend});
            if (mv == 1) evq.push_back('{0, m_dir, cyc});
            if (gr == 1) evq.push_back('{1, 7, cyc});
        end
    end

    initial begin : monitor
        st_t  st;
        evt_t e;
        forever begin
            @(negedge clock);
            if (stq.size() > 0) begin
                st = stq.pop_front();
                checks++;
                if (direction !== 3'(st.dir) || pending !== 1'(st.pend)) begin
                    errors++;
                    $display("FAIL status cyc=%0d: direction=%0d pending=%0b expected direction=%0d pending=%0d",
                             cyc, direction, pending, st.dir, st.pend);
                end
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d: no pulse seen, expected kind=%0d dir=%0d",
                         e.cyc, e.kind, e.dir);
            end
            if (move === 1'b1 || game_reset === 1'b1) begin
                checks++;
                if (move === 1'b1) begin
                    move_cycs.push_back(cyc);
                    last_move_dir = int'(direction);
                end
                if (game_reset === 1'b1) begin
                    gr_count++;
                    last_gr_cyc = cyc;
                end
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d: move=%0b game_reset=%0b expected none",
                             cyc, move, game_reset);
                end else begin
                    e = evq.pop_front();
                    if (e.cyc != cyc || (move === 1'b1 && game_reset === 1'b1) ||
                        e.kind != (game_reset === 1'b1 ? 1 : 0) ||
                        (e.kind == 0 && direction !== 3'(e.dir))) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d: move=%0b game_reset=%0b dir=%0d expected kind=%0d dir=%0d at cyc=%0d",
                                 cyc, move, game_reset, direction, e.kind, e.dir, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] b, input logic bz, input int n);
        buttons = b;
        busy = bz;
        repeat (n) @(negedge clock);
    endtask

    initial begin : stimulus
        int p, m, g, t;
        logic [3:0] pats [8];
        pats = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b1111, 4'b0000};

        // Reset held with the chord pressed.
        reset = 1'b0;
        drive(4'b1111, 1'b0, 2);
        #1;
        chk("reset_direction", int'(direction), 7);
        chk("reset_move", int'(move), 0);
        chk("reset_game_reset", int'(game_reset), 0);
        chk("reset_pending", int'(pending), 0);
        reset = 1'b1;
        drive(4'b1111, 1'b0, 10);
        drive(4'b0000, 1'b0, 12);
        #1;
        chk("no_early_chord", gr_count, 0);

        // Clean press: latency and single pulse, then a second press.
        m = move_cycs.size();
        p = cyc + 1;
        drive(4'b0100, 1'b0, 30);
        drive(4'b0000, 1'b0, 12);
        #1;
        chk("press_one_move", move_cycs.size(), m + 1);
        if (move_cycs.size() > m) chk("press_latency", move_cycs[m] - p, 8);
        chk("press_dir", last_move_dir, 0);
        drive(4'b0100, 1'b0, 20);
        drive(4'b0000, 1'b0, 12);
        #1;
        chk("second_press", move_cycs.size(), m + 2);

        // Glitchy press is rejected, then accepted when clean.
        m = move_cycs.size();
        for (int i = 0; i < 20; i++) drive((i % 3 == 2) ? 4'b0000 : 4'b0001, 1'b0, 1);
        #1;
        chk("glitch_no_move", move_cycs.size(), m);
        drive(4'b0001, 1'b0, 15);
        drive(4'b0000, 1'b0, 12);
        #1;
        chk("clean_after_glitch", move_cycs.size(), m + 1);
        chk("clean_dir", last_move_dir, 1);

        // Busy handshake; a second press while pending is dropped.
        m = move_cycs.size();
        drive(4'b1000, 1'b1, 15);
        #1;
        chk("pending_set", int'(pending), 1);
        chk("busy_no_move", move_cycs.size(), m);
        drive(4'b0010, 1'b1, 10);
        t = cyc + 1;
        drive(4'b0010, 1'b0, 10);
        drive(4'b0000, 1'b0, 12);
        #1;
        chk("busy_release_one_move", move_cycs.size(), m + 1);
        if (move_cycs.size() > m) chk("busy_release_time", move_cycs[m], t);
        chk("busy_release_dir", last_move_dir, 3);

        // Chord held long enough, then too short.
        m = move_cycs.size();
        g = gr_count;
        p = cyc + 1;
        drive(4'b1111, 1'b0, 30);
        drive(4'b0000, 1'b0, 12);
        #1;
        chk("chord_pulse", gr_count, g + 1);
        chk("chord_time", last_gr_cyc - p, 27);
        chk("chord_no_move", move_cycs.size(), m);
        drive(4'b1111, 1'b0, 10);
        drive(4'b0000, 1'b0, 12);
        #1;
        chk("short_chord", gr_count, g + 1);

        // Long single-button hold.
        m = move_cycs.size();
        drive(4'b0010, 1'b0, 45);
        drive(4'b0000, 1'b0, 15);
        #1;
`ifdef NAV_AUTOREPEAT_EN
        chk("repeat_some", int'(move_cycs.size() >= m + 2), 1);
        if (move_cycs.size() >= m + 2) chk("repeat_period", move_cycs[m+1] - move_cycs[m], 11);
`else
        chk("hold_one_move", move_cycs.size(), m + 1);
`endif
        chk("hold_dir", last_move_dir, 2);

        // Reset while pending and mid-chord discards progress.
        m = move_cycs.size();
        g = gr_count;
        drive(4'b1000, 1'b1, 12);
        reset = 1'b0;
        drive(4'b1000, 1'b1, 2);
        reset = 1'b1;
        drive(4'b0000, 1'b0, 15);
        drive(4'b1111, 1'b0, 20);
        reset = 1'b0;
        drive(4'b1111, 1'b0, 2);
        reset = 1'b1;
        drive(4'b1111, 1'b0, 15);
        drive(4'b0000, 1'b0, 12);
        #1;
        chk("reset_drops_pending", move_cycs.size(), m);
        chk("reset_drops_chord", gr_count, g);

        // Randomized traffic.
        for (int s = 0; s < 250; s++) begin
            logic [3:0] b;
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                drive(buttons, busy, $urandom_range(1, 2));
                reset = 1'b1;
            end
            b = pats[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) b = 4'($urandom);
            drive(b, ($urandom_range(0, 3) == 0), $urandom_range(1, 35));
        end

        drive(4'b0000, 1'b0, 60);
        #1;
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d outstanding expected 0", evq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
